// File: rtl/tiny_axi_lite_8bit_master.sv
// Single-outstanding AXI4-Lite initiator: one command in, AW/W/B or AR/R out, one response back.
// A per-transaction timeout aborts stuck handshakes so bring-up never hangs the command port.
module tiny_axi_lite_8bit_master #(
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   AWADDR,
  output logic                    AWVALID,
  input  logic                    AWREADY,
  output logic [DATA_WIDTH-1:0]   WDATA,
  output logic [DATA_WIDTH/8-1:0] WSTRB,
  output logic                    WVALID,
  input  logic                    WREADY,
  input  logic                    BVALID,
  input  logic [1:0]              BRESP,
  output logic                    BREADY,
  output logic [ADDR_WIDTH-1:0]   ARADDR,
  output logic                    ARVALID,
  input  logic                    ARREADY,
  input  logic                    RVALID,
  input  logic [DATA_WIDTH-1:0]   RDATA,
  input  logic [1:0]              RRESP,
  output logic                    RREADY
);
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] TO_VAL  = CW'(TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_WRESP, S_RADDR, S_RDATA, S_RSP} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d, cnt_inc;
  logic                    aw_done_q, aw_done_d, w_done_q, w_done_d, write_q, write_d;
  logic                    cmd_ready_q, cmd_ready_d, rsp_valid_q, rsp_valid_d;
  logic                    rsp_write_q, rsp_write_d, rsp_timeout_q, rsp_timeout_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d, wdata_q, wdata_d;
  logic [1:0]              rsp_resp_q, rsp_resp_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic                    awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic                    arvalid_q, arvalid_d, rready_q, rready_d;

  logic accept, active, timeout_hit, abort;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_all, w_all;

  assign accept  = (state_q == S_IDLE) && cmd_valid && cmd_ready_q;
  assign active  = state_q inside {S_WRITE, S_WRESP, S_RADDR, S_RDATA};
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  assign aw_hs   = awvalid_q & AWREADY;
  assign w_hs    = wvalid_q & WREADY;
  assign b_hs    = bready_q & BVALID;
  assign ar_hs   = arvalid_q & ARREADY;
  assign r_hs    = rready_q & RVALID;
  assign aw_all  = aw_done_q | aw_hs;
  assign w_all   = w_done_q | w_hs;

  // A handshake landing in the cycle the counter reaches TIMEOUT completes normally.
  assign timeout_hit = (TIMEOUT != 0) && active && (cnt_inc == TO_VAL);
  assign abort = timeout_hit && !(((state_q == S_WRITE) && aw_all && w_all) ||
                                  ((state_q == S_WRESP) && b_hs) ||
                                  ((state_q == S_RADDR) && ar_hs) ||
                                  ((state_q == S_RDATA) && r_hs));

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      write_q       <= 1'b0;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_write_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= '0;
      awaddr_q      <= '0;
      araddr_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      aw_done_q     <= aw_done_d;
      w_done_q      <= w_done_d;
      write_q       <= write_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_write_q   <= rsp_write_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      awaddr_q      <= awaddr_d;
      araddr_q      <= araddr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = cmd_write ? S_WRITE : S_RADDR;
      S_WRITE: if (aw_all && w_all) state_d = S_WRESP;
               else if (abort) state_d = S_RSP;
      S_WRESP: if (b_hs || abort) state_d = S_RSP;
      S_RADDR: if (ar_hs) state_d = S_RDATA;
               else if (abort) state_d = S_RSP;
      S_RDATA: if (r_hs || abort) state_d = S_RSP;
      S_RSP:   if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d         = active ? cnt_inc : cnt_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    write_d       = write_q;
    cmd_ready_d   = cmd_ready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_write_d   = rsp_write_q;
    rsp_timeout_d = rsp_timeout_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    awaddr_d      = awaddr_q;
    araddr_d      = araddr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    case (state_q)
      S_IDLE: begin
        cmd_ready_d = 1'b1;
        if (accept) begin
          cmd_ready_d = 1'b0;
          cnt_d       = '0;
          write_d     = cmd_write;
          aw_done_d   = 1'b0;
          w_done_d    = 1'b0;
          if (cmd_write) begin
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            araddr_d  = cmd_addr;
            arvalid_d = 1'b1;
          end
        end
      end
      S_WRITE: begin
        aw_done_d = aw_all;
        w_done_d  = w_all;
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs) wvalid_d = 1'b0;
        if (aw_all && w_all) bready_d = 1'b1;
      end
      S_WRESP: if (b_hs) begin
        bready_d      = 1'b0;
        rsp_valid_d   = 1'b1;
        rsp_write_d   = 1'b1;
        rsp_rdata_d   = '0;
        rsp_resp_d    = BRESP;
        rsp_timeout_d = 1'b0;
      end
      S_RADDR: if (ar_hs) begin
        arvalid_d = 1'b0;
        rready_d  = 1'b1;
      end
      S_RDATA: if (r_hs) begin
        rready_d      = 1'b0;
        rsp_valid_d   = 1'b1;
        rsp_write_d   = 1'b0;
        rsp_rdata_d   = RDATA;
        rsp_resp_d    = RRESP;
        rsp_timeout_d = 1'b0;
      end
      S_RSP: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        cmd_ready_d = 1'b1;
      end
      default: ;
    endcase
    // Abort drops every handshake signal; stale B/R beats are the slave's problem after this.
    if (abort) begin
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      bready_d      = 1'b0;
      arvalid_d     = 1'b0;
      rready_d      = 1'b0;
      rsp_valid_d   = 1'b1;
      rsp_write_d   = write_q;
      rsp_rdata_d   = '0;
      rsp_resp_d    = 2'b10;
      rsp_timeout_d = 1'b1;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_write   = rsp_write_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_resp    = rsp_resp_q;
  assign rsp_timeout = rsp_timeout_q;
  assign AWADDR      = awaddr_q;
  assign AWVALID     = awvalid_q;
  assign WDATA       = wdata_q;
  assign WSTRB       = wstrb_q;
  assign WVALID      = wvalid_q;
  assign BREADY      = bready_q;
  assign ARADDR      = araddr_q;
  assign ARVALID     = arvalid_q;
  assign RREADY      = rready_q;

endmodule
